// File: rtl/frame_commit_ctrl.sv
// Commits a game frame into the back half of the VGA double buffer one word per cycle,
// then swaps buffers on the next rising edge of vertical blanking.
module frame_commit_ctrl #(
    parameter int FRAME_BITS = 1344,
    parameter int WORD_W     = 32,
    parameter int NUM_WORDS  = FRAME_BITS / WORD_W,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] frame_in,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    input  logic                  vblank,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [WORD_W-1:0]     wr_data,
    output logic                  wr_buf_sel,
    output logic                  disp_buf,
    output logic                  swap_pulse,
    output logic                  busy,
    output logic [7:0]            frames_dropped
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_VB
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    state_t                             state;
    state_t                             state_next;
    logic [NUM_WORDS-1:0][WORD_W-1:0]   snap;
    logic [ADDR_W-1:0]                  word_cnt;
    logic                               vblank_q;
    logic                               vb_rise;
    logic                               accept;
    logic                               swap;

    assign vb_rise = vblank & ~vblank_q;
    assign accept  = (state == IDLE) & frame_valid;
    assign swap    = (state == WAIT_VB) & vb_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (frame_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (word_cnt == LAST_WORD) begin
                    state_next = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vb_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        frame_ready = 1'b0;
        busy        = 1'b1;
        wr_en       = 1'b0;
        case (state)
            IDLE: begin
                frame_ready = 1'b1;
                busy        = 1'b0;
            end
            LOAD: begin
                wr_en = 1'b1;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // word_cnt parks on the last word after LOAD, so address and data hold their final value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap     <= '0;
            word_cnt <= '0;
        end else if (accept) begin
            snap     <= frame_in;
            word_cnt <= '0;
        end else if ((state == LOAD) && (word_cnt != LAST_WORD)) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    assign wr_addr = word_cnt;
    assign wr_data = snap[word_cnt];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblank_q   <= 1'b0;
            disp_buf   <= 1'b0;
            swap_pulse <= 1'b0;
        end else begin
            vblank_q   <= vblank;
            swap_pulse <= swap;
            if (swap) begin
                disp_buf <= ~disp_buf;
            end
        end
    end

    assign wr_buf_sel = ~disp_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_dropped <= 8'd0;
        end else if (frame_valid && (state != IDLE) && (frames_dropped != 8'hFF)) begin
            frames_dropped <= frames_dropped + 8'd1;
        end
    end

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// Directed bench for frame_commit_ctrl: write sequencing, vblank-edge swaps, drops,
// saturation and reset abort, all with hand-computed expectations.
module tb_frame_commit_ctrl;

    localparam int FRAME_BITS = 1344;
    localparam int WORD_W     = 32;
    localparam int NUM_WORDS  = 42;
    localparam int ADDR_W     = 6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [FRAME_BITS-1:0] frame_in;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  vblank;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [WORD_W-1:0]     wr_data;
    logic                  wr_buf_sel;
    logic                  disp_buf;
    logic                  swap_pulse;
    logic                  busy;
    logic [7:0]            frames_dropped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_commit_ctrl #(
        .FRAME_BITS(FRAME_BITS),
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_in      (frame_in),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .vblank        (vblank),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_buf_sel    (wr_buf_sel),
        .disp_buf      (disp_buf),
        .swap_pulse    (swap_pulse),
        .busy          (busy),
        .frames_dropped(frames_dropped)
    );

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [31:0] base);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            f[i*WORD_W +: WORD_W] = base + 32'(i);
        end
        return f;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Accepts a frame now, checks all 42 writes, and leaves the bench on the first WAIT_VB cycle
    task automatic apply_stimulus(input logic [31:0] base, input logic exp_sel, input int pulse_at,
                                  input int vb_up_at, input int vb_down_at, input logic exp_disp);
        frame_in    = make_frame(base);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        for (int t = 1; t <= NUM_WORDS; t++) begin
            check_output("load_wr_en", 32'(wr_en), 32'd1);
            check_output("load_addr", 32'(wr_addr), 32'(t - 1));
            check_output("load_data", wr_data, base + 32'(t - 1));
            check_output("load_sel", 32'(wr_buf_sel), 32'(exp_sel));
            check_output("load_ready", 32'(frame_ready), 32'd0);
            check_output("load_swap", 32'(swap_pulse), 32'd0);
            frame_valid = (t == pulse_at);
            if (t == pulse_at) frame_in = ~make_frame(base);
            if (t == vb_up_at) vblank = 1'b1;
            if (t == vb_down_at) vblank = 1'b0;
            step();
        end
        frame_valid = 1'b0;
        check_output("wait_wr_en", 32'(wr_en), 32'd0);
        check_output("wait_busy", 32'(busy), 32'd1);
        check_output("wait_ready", 32'(frame_ready), 32'd0);
        check_output("wait_addr_hold", 32'(wr_addr), 32'(NUM_WORDS - 1));
        check_output("wait_data_hold", wr_data, base + 32'(NUM_WORDS - 1));
        check_output("wait_disp", 32'(disp_buf), 32'(exp_disp));
    endtask

    initial begin
        rst         = 1'b0;
        frame_valid = 1'b0;
        vblank      = 1'b0;
        frame_in    = '0;
        step();
        step();
        check_output("rst_ready", 32'(frame_ready), 32'd1);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_wr_en", 32'(wr_en), 32'd0);
        check_output("rst_addr", 32'(wr_addr), 32'd0);
        check_output("rst_data", wr_data, 32'd0);
        check_output("rst_disp", 32'(disp_buf), 32'd0);
        check_output("rst_sel", 32'(wr_buf_sel), 32'd1);
        check_output("rst_swap", 32'(swap_pulse), 32'd0);
        check_output("rst_dropped", 32'(frames_dropped), 32'd0);
        rst = 1'b1;
        step();
        check_output("idle_ready", 32'(frame_ready), 32'd1);

        $display("[TB] basic commit with drop at T5 and vblank already high on WAIT_VB entry");
        apply_stimulus(32'hA5A5_0000, 1'b1, 5, 30, 0, 1'b0);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_output("vb_high_no_swap", 32'(swap_pulse), 32'd0);
            check_output("vb_high_disp", 32'(disp_buf), 32'd0);
            step();
        end
        vblank = 1'b0;
        for (int k = 0; k < 100; k++) begin
            check_output("vb_low_no_swap", 32'(swap_pulse), 32'd0);
            step();
        end
        vblank = 1'b1;
        step();
        check_output("swap1_pulse", 32'(swap_pulse), 32'd1);
        check_output("swap1_disp", 32'(disp_buf), 32'd1);
        check_output("swap1_sel", 32'(wr_buf_sel), 32'd0);
        check_output("swap1_ready", 32'(frame_ready), 32'd1);
        check_output("swap1_busy", 32'(busy), 32'd0);
        check_output("swap1_dropped", 32'(frames_dropped), 32'd2);

        $display("[TB] accept on swap cycle, then reset at T10");
        vblank      = 1'b0;
        frame_in    = make_frame(32'h0BAD_0000);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check_output("abort_swap_cleared", 32'(swap_pulse), 32'd0);
        check_output("abort_wr_en", 32'(wr_en), 32'd1);
        check_output("abort_addr0", 32'(wr_addr), 32'd0);
        check_output("abort_data0", wr_data, 32'h0BAD_0000);
        for (int t = 2; t <= 10; t++) step();
        check_output("abort_addr9", 32'(wr_addr), 32'd9);
        rst = 1'b0;
        #1;
        check_output("abort_rst_wr_en", 32'(wr_en), 32'd0);
        check_output("abort_rst_ready", 32'(frame_ready), 32'd1);
        check_output("abort_rst_busy", 32'(busy), 32'd0);
        check_output("abort_rst_disp", 32'(disp_buf), 32'd0);
        check_output("abort_rst_sel", 32'(wr_buf_sel), 32'd1);
        check_output("abort_rst_addr", 32'(wr_addr), 32'd0);
        check_output("abort_rst_dropped", 32'(frames_dropped), 32'd0);
        step();
        step();
        step();
        rst    = 1'b1;
        vblank = 1'b1;
        step();
        check_output("post_rst_no_swap", 32'(swap_pulse), 32'd0);
        check_output("post_rst_disp", 32'(disp_buf), 32'd0);
        step();
        check_output("post_rst_no_swap2", 32'(swap_pulse), 32'd0);
        vblank = 1'b0;
        step();

        $display("[TB] frame A with vblank edge ignored during LOAD");
        apply_stimulus(32'h1357_0000, 1'b1, 0, 20, 25, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check_output("ignored_edge_no_swap", 32'(swap_pulse), 32'd0);
            check_output("ignored_edge_disp", 32'(disp_buf), 32'd0);
            step();
        end
        vblank = 1'b1;
        step();
        check_output("swapA_pulse", 32'(swap_pulse), 32'd1);
        check_output("swapA_disp", 32'(disp_buf), 32'd1);
        check_output("swapA_sel", 32'(wr_buf_sel), 32'd0);

        $display("[TB] frame B into buffer 0 with drop saturation");
        vblank = 1'b0;
        apply_stimulus(32'h2468_0000, 1'b0, 0, 0, 0, 1'b1);
        for (int k = 0; k < 300; k++) begin
            frame_valid = 1'b1;
            step();
            if (k == 9) check_output("dropped_10", 32'(frames_dropped), 32'd10);
        end
        frame_valid = 1'b0;
        check_output("dropped_sat", 32'(frames_dropped), 32'd255);
        check_output("sat_still_waiting", 32'(frame_ready), 32'd0);
        vblank = 1'b1;
        step();
        check_output("swapB_pulse", 32'(swap_pulse), 32'd1);
        check_output("swapB_disp", 32'(disp_buf), 32'd0);
        check_output("swapB_sel", 32'(wr_buf_sel), 32'd1);
        check_output("swapB_ready", 32'(frame_ready), 32'd1);
        check_output("swapB_dropped", 32'(frames_dropped), 32'd255);
        step();
        check_output("swapB_pulse_end", 32'(swap_pulse), 32'd0);
        check_output("swapB_disp_hold", 32'(disp_buf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
